spread_calc: RTL and testbench
==============================

// Module: spread_calc
// PURPOSE
//  Computes the Avellaneda-Stoikov optimal bid/ask spread for the market-making datapath:
//  spread = RISK_FACTOR*vol^2*(TERMINAL_TIME - t) + LOGARITHM.
//  Fully pipelined; accepts one sample per clock.
//  Feeds the quote generator alongside the reservation-price block.
// PARAMETERS
//  DATA_WIDTH     32     width of every data port; Q16.16 for fractional quantities (DATA_WIDTH=32)
//  LOGARITHM      121    precomputed (2/gamma)*ln(1+gamma/k) term, raw Q16.16 unsigned
//  RISK_FACTOR    6554   gamma, raw Q16.16 unsigned (6554 ~= 0.1)
//  TERMINAL_TIME  10000  session end time T, unsigned integer ticks
// PORTS
//  i_clk         in   1           clock, all logic on rising edge
//  i_rst_n       in   1           asynchronous active-low reset
//  i_curr_time   in   DATA_WIDTH  current time t, unsigned integer ticks
//  i_volatility  in   DATA_WIDTH  sigma, unsigned Q16.16
//  i_data_valid  in   1           qualifies i_curr_time/i_volatility this cycle
//  o_spread      out  DATA_WIDTH  spread, unsigned Q16.16, saturating
//  o_data_valid  out  1           o_spread valid this cycle (single-cycle pulse per sample)
// BEHAVIOUR
//  - Reset (async assert, sync release): all pipeline regs, o_spread=0, o_data_valid=0.
//  - Latency exactly 4 cycles from i_data_valid sample edge to o_data_valid high; throughput 1/clk.
//  - No backpressure; valid shifts through a 4-deep valid chain alongside data.
//  - Data regs load only when their stage valid is high; else hold (o_spread holds last value).
//  - S1: sig2 = (vol*vol)>>16; tleft = (t >= TERMINAL_TIME) ? 0 : TERMINAL_TIME - t.
//  - S2: g = (RISK_FACTOR*sig2)>>16.
//  - S3: p = g*tleft (tleft integer, no shift).
//  - S4: o_spread = p + LOGARITHM.
//  - Products computed 2*DATA_WIDTH wide.
//  - Every stage result saturates to 2^DATA_WIDTH-1 on overflow.
//  - All arithmetic unsigned, truncating (floor) on right shifts.
//  - t >= TERMINAL_TIME -> spread = LOGARITHM exactly (no negative time).
//  - vol=0 -> spread = LOGARITHM.
//  - Reset mid-operation flushes all in-flight samples; none emerge after release.
// STRUCTURE
//  - Shared package hft_pkg: DATA_WIDTH default, Q16.16 FRAC_BITS=16 constant,
//    data_t typedef, sat_mul/sat_add functions.
//  - One natural sub-module: sat_mul_q (registered unsigned multiply, shift, saturate).
//    Instantiated twice for S1 sig2 and S2; S3 uses it with shift 0.
// TESTING
//  1. vol=65536 (1.0), t=0, valid 1 cycle -> after 4 clks o_spread=65540121, o_data_valid 1 cycle.
//  2. vol=32768 (0.5), t=9000 -> o_spread=1638121 (sig2=16384, g=1638, *1000, +121).
//  3. t=10000 and t=20000, vol=65536 -> o_spread=121 both.
//  4. vol=0xFFFFFFFF, t=0 -> o_spread=0xFFFFFFFF (saturation, no wrap).
//  5. Back-to-back valid on 3 cycles with cases 1,2,3 -> outputs on 3 consecutive cycles, in order.
//  6. Assert i_rst_n=0 two cycles after a valid input -> o_data_valid stays 0, o_spread=0 immediately.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared fixed-point types and saturating arithmetic helpers for the market-making datapath.
package hft_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned FRAC_BITS  = 16;
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [PROD_WIDTH-1:0] prod_t;

    // Full-width unsigned product, floor right shift, clamp to all-ones on overflow.
    function automatic data_t sat_mul(input data_t a, input data_t b, input int unsigned shift);
        prod_t prod;
        prod_t shifted;
        prod    = PROD_WIDTH'(a) * PROD_WIDTH'(b);
        shifted = prod >> shift;
        if (|shifted[PROD_WIDTH-1:DATA_WIDTH]) begin
            return '1;
        end
        return shifted[DATA_WIDTH-1:0];
    endfunction

    // Unsigned add, clamp to all-ones when the carry-out is set.
    function automatic data_t sat_add(input data_t a, input data_t b);
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[DATA_WIDTH]) begin
            return '1;
        end
        return sum[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sat_mul_q.sv
// Registered unsigned multiply with fixed right shift and saturation to the data width.
module sat_mul_q
    import hft_pkg::*;
#(
    parameter int unsigned SHIFT = FRAC_BITS
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  data_t a,
    input  data_t b,
    output data_t y
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (en) begin
            y <= sat_mul(a, b, SHIFT);
        end
    end

endmodule

// File: rtl/spread_calc.sv
// Avellaneda-Stoikov spread: RISK_FACTOR*vol^2*(TERMINAL_TIME - t) + LOGARITHM, four-stage pipeline.
module spread_calc
    import hft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = hft_pkg::DATA_WIDTH,
    parameter int unsigned LOGARITHM     = 121,
    parameter int unsigned RISK_FACTOR   = 6554,
    parameter int unsigned TERMINAL_TIME = 10000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_curr_time,
    input  logic [DATA_WIDTH-1:0] i_volatility,
    input  logic                  i_data_valid,
    output logic [DATA_WIDTH-1:0] o_spread,
    output logic                  o_data_valid
);

    localparam data_t LOG_TERM  = data_t'(LOGARITHM);
    localparam data_t GAMMA     = data_t'(RISK_FACTOR);
    localparam data_t T_END     = data_t'(TERMINAL_TIME);

    logic  valid_s1;
    logic  valid_s2;
    logic  valid_s3;

    data_t sig2_s1;
    data_t tleft_s1;
    data_t g_s2;
    data_t tleft_s2;
    data_t p_s3;
    data_t tleft_c;

    // Remaining session time, clamped at zero once the session has ended.
    always_comb begin
        tleft_c = '0;
        if (i_curr_time < T_END) begin
            tleft_c = T_END - i_curr_time;
        end
    end

    // Valid chain travels with the data; no backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_s1     <= 1'b0;
            valid_s2     <= 1'b0;
            valid_s3     <= 1'b0;
            o_data_valid <= 1'b0;
        end else begin
            valid_s1     <= i_data_valid;
            valid_s2     <= valid_s1;
            valid_s3     <= valid_s2;
            o_data_valid <= valid_s3;
        end
    end

    // Time-left side path, aligned with the multiplier stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tleft_s1 <= '0;
            tleft_s2 <= '0;
        end else begin
            if (i_data_valid) begin
                tleft_s1 <= tleft_c;
            end
            if (valid_s1) begin
                tleft_s2 <= tleft_s1;
            end
        end
    end

    sat_mul_q #(.SHIFT(FRAC_BITS)) u_sig2 (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (i_data_valid),
        .a     (i_volatility),
        .b     (i_volatility),
        .y     (sig2_s1)
    );

    sat_mul_q #(.SHIFT(FRAC_BITS)) u_gamma (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (valid_s1),
        .a     (GAMMA),
        .b     (sig2_s1),
        .y     (g_s2)
    );

    // Time left is an integer tick count, so this product keeps its Q16.16 scale.
    sat_mul_q #(.SHIFT(0)) u_time (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (valid_s2),
        .a     (g_s2),
        .b     (tleft_s2),
        .y     (p_s3)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_spread <= '0;
        end else if (valid_s3) begin
            o_spread <= sat_add(p_s3, LOG_TERM);
        end
    end

endmodule

// File: tb/tb_spread_calc.sv
// Directed bench for spread_calc: latency, arithmetic, clamps, saturation, streaming and reset flush.
module tb_spread_calc;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_curr_time;
    logic [31:0] i_volatility;
    logic        i_data_valid;
    logic [31:0] o_spread;
    logic        o_data_valid;

    int passed = 0;
    int total  = 0;

    spread_calc dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_curr_time  (i_curr_time),
        .i_volatility (i_volatility),
        .i_data_valid (i_data_valid),
        .o_spread     (o_spread),
        .o_data_valid (o_data_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one sample for a single cycle, then follow it to the output with exact-latency checks.
    task automatic run_single(input string tag, input logic [31:0] vol, input logic [31:0] t,
                              input logic [31:0] exp);
        @(negedge i_clk);
        i_volatility = vol;
        i_curr_time  = t;
        i_data_valid = 1'b1;
        @(negedge i_clk);
        i_data_valid = 1'b0;
        i_volatility = 32'hDEAD_BEEF;
        i_curr_time  = 32'h0000_0005;
        @(negedge i_clk);
        check({tag, "_v_early2"}, {31'd0, o_data_valid}, 32'd0);
        @(negedge i_clk);
        check({tag, "_v_early3"}, {31'd0, o_data_valid}, 32'd0);
        @(negedge i_clk);
        check({tag, "_valid"}, {31'd0, o_data_valid}, 32'd1);
        check({tag, "_spread"}, o_spread, exp);
        @(negedge i_clk);
        check({tag, "_v_pulse"}, {31'd0, o_data_valid}, 32'd0);
        check({tag, "_hold"}, o_spread, exp);
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_curr_time  = '0;
        i_volatility = '0;
        i_data_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_spread", o_spread, 32'd0);
        check("rst_valid", {31'd0, o_data_valid}, 32'd0);
        i_rst_n = 1'b1;

        run_single("unit_vol",  32'd65536,    32'd0,     32'd65540121);
        run_single("half_vol",  32'd32768,    32'd9000,  32'd1638121);
        run_single("t_end",     32'd65536,    32'd10000, 32'd121);
        run_single("t_past",    32'd65536,    32'd20000, 32'd121);
        run_single("sat",       32'hFFFF_FFFF, 32'd0,    32'hFFFF_FFFF);
        run_single("zero_vol",  32'd0,        32'd0,     32'd121);

        // Three back-to-back samples must emerge on three consecutive cycles, in order.
        @(negedge i_clk);
        i_data_valid = 1'b1;
        i_volatility = 32'd65536; i_curr_time = 32'd0;
        @(negedge i_clk);
        i_volatility = 32'd32768; i_curr_time = 32'd9000;
        @(negedge i_clk);
        i_volatility = 32'd65536; i_curr_time = 32'd10000;
        @(negedge i_clk);
        i_data_valid = 1'b0;
        @(negedge i_clk);
        check("b2b_v0", {31'd0, o_data_valid}, 32'd1);
        check("b2b_s0", o_spread, 32'd65540121);
        @(negedge i_clk);
        check("b2b_v1", {31'd0, o_data_valid}, 32'd1);
        check("b2b_s1", o_spread, 32'd1638121);
        @(negedge i_clk);
        check("b2b_v2", {31'd0, o_data_valid}, 32'd1);
        check("b2b_s2", o_spread, 32'd121);
        @(negedge i_clk);
        check("b2b_end", {31'd0, o_data_valid}, 32'd0);

        // Reset with a sample in flight: outputs clear at once and nothing emerges afterwards.
        @(negedge i_clk);
        i_volatility = 32'd65536; i_curr_time = 32'd0;
        i_data_valid = 1'b1;
        @(negedge i_clk);
        i_data_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("flush_spread", o_spread, 32'd0);
        check("flush_valid", {31'd0, o_data_valid}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            check($sformatf("flush_quiet%0d", i), {31'd0, o_data_valid}, 32'd0);
        end
        check("flush_spread_end", o_spread, 32'd0);

        // Pipeline must be fully usable again after the flush.
        run_single("post_rst", 32'd32768, 32'd9000, 32'd1638121);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
